// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and sign helpers shared by mdu_unit and the EX stage.
package mdu_pkg;
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MADD  = 3'd4;
    localparam logic [2:0] MDU_MADDU = 3'd5;
    localparam logic [2:0] MDU_MSUB  = 3'd6;
    localparam logic [2:0] MDU_MSUBU = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_ACC, S_DSETUP, S_DITER, S_FIX, S_DONE
    } mdu_state_e;

    function automatic logic mdu_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

    // Whether a value must be negated to take its magnitude, or to restore its sign afterwards.
    function automatic logic mdu_neg(input logic sgn, input logic msb);
        return sgn & msb;
    endfunction
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: restoring radix-2 divider on magnitudes, one quotient bit per cycle.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         cancel_i,
    input  logic [W-1:0] dvd_i,
    input  logic [W-1:0] dvs_i,
    output logic         done_o,
    output logic [W-1:0] quo_o,
    output logic [W-1:0] rem_o
);
    localparam int CW = $clog2(W);

    logic          run_q, last;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  quo_q, rem_q, dvs_q;
    logic [W:0]    rem_sh, diff;

    assign rem_sh = {rem_q, quo_q[W-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign last   = cnt_q == CW'(W - 1);
    assign done_o = run_q & last;
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (cancel_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            quo_q <= dvd_i;
            rem_q <= '0;
            dvs_q <= dvs_i;
        end else if (run_q) begin
            rem_q <= diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
            quo_q <= {quo_q[W-2:0], ~diff[W]};
            cnt_q <= last ? '0 : cnt_q + CW'(1);
            run_q <= ~last;
        end
    end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: iterative HI/LO multiply/divide unit with start/busy/valid handshake.
// MDU_ACCUM_EN builds the MADD/MSUB accumulate stage; otherwise ops 4-7 pass {hi_i,lo_i} through.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [2:0]     op_i,
    input  logic [W-1:0]   opa_i,
    input  logic [W-1:0]   opb_i,
    input  logic [W-1:0]   hi_i,
    input  logic [W-1:0]   lo_i,
    input  logic           cancel_i,
    output logic           busy_o,
    output logic           valid_o,
    output logic [2*W-1:0] result_o,
    output logic           div_zero_o
);
    mdu_state_e     state_q, state_d;
    logic           sgn_q, acc_q, dz_q, dz_d;
    logic [W-1:0]   a_q, b_q, hi_q, lo_q;
    logic [2*W-1:0] result_q, result_d;
    logic           accept, core_start, core_cancel, core_done, a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag, dvd, dvs, quo, rem, quo_s, rem_s;
    logic [2*W-1:0] prod_mag, prod;

    assign accept     = state_q == S_IDLE && start_i;
    assign a_neg      = mdu_neg(sgn_q, a_q[W-1]);
    assign b_neg      = mdu_neg(sgn_q, b_q[W-1]);
    assign a_mag      = a_neg ? -a_q : a_q;
    assign b_mag      = b_neg ? -b_q : b_q;
    assign prod_mag   = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
    assign prod       = (a_neg ^ b_neg) ? -prod_mag : prod_mag;
    assign quo_s      = (a_neg ^ b_neg) ? -quo : quo;
    assign rem_s      = a_neg ? -rem : rem;
    // The divider loads straight from the ports at accept, so DSETUP already runs iteration 0.
    assign dvd        = mdu_neg(mdu_signed(op_i), opa_i[W-1]) ? -opa_i : opa_i;
    assign dvs        = mdu_neg(mdu_signed(op_i), opb_i[W-1]) ? -opb_i : opb_i;
    assign core_start = accept && mdu_is_div(op_i);
    assign core_cancel = (cancel_i && state_q != S_IDLE) || (state_q == S_DSETUP && b_q == '0);

    mdu_div_core #(.W(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start_i  (core_start),
        .cancel_i (core_cancel),
        .dvd_i    (dvd),
        .dvs_i    (dvs),
        .done_o   (core_done),
        .quo_o    (quo),
        .rem_o    (rem)
    );

`ifdef MDU_ACCUM_EN
    logic           sub_q;
    logic [2*W-1:0] prod_q, acc;
    assign acc = sub_q ? {hi_q, lo_q} - prod_q : {hi_q, lo_q} + prod_q;
    always_ff @(posedge clk) begin
        if (accept) sub_q <= op_i[1];
        if (state_q == S_MUL) prod_q <= prod;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sgn_q <= mdu_signed(op_i);
            acc_q <= op_i[2];
            a_q   <= opa_i;
            b_q   <= opb_i;
            hi_q  <= hi_i;
            lo_q  <= lo_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = start_i ? (mdu_is_div(op_i) ? S_DSETUP : S_MUL) : S_IDLE;
`ifdef MDU_ACCUM_EN
            S_MUL:    state_d = acc_q ? S_ACC : S_DONE;
            S_ACC:    state_d = S_DONE;
`else
            S_MUL:    state_d = S_DONE;
`endif
            S_DSETUP: state_d = b_q == '0 ? S_DONE : S_DITER;
            S_DITER:  state_d = core_done ? S_FIX : S_DITER;
            S_FIX:    state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
        if (cancel_i && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_comb begin
        result_d = result_q;
        dz_d     = dz_q;
        if (!cancel_i) begin
            case (state_q)
`ifdef MDU_ACCUM_EN
                S_MUL: if (!acc_q) begin
                    result_d = prod;
                    dz_d     = 1'b0;
                end
                S_ACC: begin
                    result_d = acc;
                    dz_d     = 1'b0;
                end
`else
                S_MUL: begin
                    result_d = acc_q ? {hi_q, lo_q} : prod;
                    dz_d     = 1'b0;
                end
`endif
                S_DSETUP: if (b_q == '0) begin
                    result_d = {a_q, {W{1'b1}}};
                    dz_d     = 1'b1;
                end
                S_FIX: begin
                    result_d = {rem_s, quo_s};
                    dz_d     = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy_o     = state_q != S_IDLE;
    assign valid_o    = state_q == S_DONE;
    assign result_o   = result_q;
    assign div_zero_o = dz_q;
endmodule
